// File: rtl/w_mux4_rr_arbiter_if.sv
// Request/grant/select bundle between the four requesters and the round-robin arbiter.
// The master modport is the arbiter side; the slave modport is the requester/selector side.
interface w_mux4_rr_arbiter_if;
  logic [3:0] Req;
  logic [3:0] Grant;
  logic       Sel0;
  logic       Sel1;
  logic       Valid;
  logic [1:0] Owner;

  modport master (
    input  Req,
    output Grant,
    output Sel0,
    output Sel1,
    output Valid,
    output Owner
  );

  modport slave (
    output Req,
    input  Grant,
    input  Sel0,
    input  Sel1,
    input  Valid,
    input  Owner
  );
endinterface

// File: rtl/w_mux4_rr_arbiter.sv
// Round-robin arbiter steering a shared 4-to-1 selector; a hold counter bounds how long
// one owner may keep the path while others wait. All outputs come straight from registers.
module w_mux4_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  w_mux4_rr_arbiter_if.master    bus
);

  localparam logic [1:0]       ST_IDLE    = 2'd0;
  localparam logic [1:0]       ST_GRANT   = 2'd1;
  localparam logic [1:0]       ST_RELEASE = 2'd2;
  localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

  logic [1:0]       r_state;
  logic [1:0]       r_last;
  logic [1:0]       r_owner;
  logic [3:0]       r_grant;
  logic             r_valid;
  logic             r_sel0;
  logic             r_sel1;
  logic [CNT_W-1:0] r_cnt;

  logic [3:0]       w_rot;
  logic [1:0]       w_off;
  logic [1:0]       w_winner;
  logic             w_owner_req;
  logic             w_rival;
  logic             w_hold_done;

  function automatic logic [3:0] one_hot(input logic [1:0] idx);
    case (idx)
      2'd0:    one_hot = 4'b0001;
      2'd1:    one_hot = 4'b0010;
      2'd2:    one_hot = 4'b0100;
      2'd3:    one_hot = 4'b1000;
      default: one_hot = 4'b0000;
    endcase
  endfunction

  // Rotate requests so bit 0 is the requester just after the last owner, then take the first hit.
  always_comb begin
    w_rot = 4'b0000;
    w_off = 2'd0;
    case (r_last)
      2'd0:    w_rot = {bus.Req[0], bus.Req[3], bus.Req[2], bus.Req[1]};
      2'd1:    w_rot = {bus.Req[1], bus.Req[0], bus.Req[3], bus.Req[2]};
      2'd2:    w_rot = {bus.Req[2], bus.Req[1], bus.Req[0], bus.Req[3]};
      2'd3:    w_rot = bus.Req;
      default: w_rot = 4'b0000;
    endcase
    casez (w_rot)
      4'b???1: w_off = 2'd0;
      4'b??10: w_off = 2'd1;
      4'b?100: w_off = 2'd2;
      4'b1000: w_off = 2'd3;
      default: w_off = 2'd0;
    endcase
    w_winner    = r_last + 2'd1 + w_off;
    w_owner_req = bus.Req[r_owner];
    w_rival     = |(bus.Req & ~r_grant);
    w_hold_done = (r_cnt >= HOLD_LIM);
  end

  // Arbitration state machine; Sel only moves on a new grant so Result is stable while Valid.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_last  <= 2'd3;
      r_owner <= 2'd0;
      r_grant <= 4'b0000;
      r_valid <= 1'b0;
      r_sel0  <= 1'b0;
      r_sel1  <= 1'b0;
      r_cnt   <= CNT_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|bus.Req) begin
            r_state <= ST_GRANT;
            r_owner <= w_winner;
            r_grant <= one_hot(w_winner);
            r_sel0  <= w_winner[1];
            r_sel1  <= w_winner[0];
            r_valid <= 1'b1;
            r_cnt   <= CNT_ONE;
          end
        end
        ST_GRANT: begin
          if (!w_owner_req || (w_hold_done && w_rival)) begin
            r_state <= ST_RELEASE;
            r_grant <= 4'b0000;
            r_valid <= 1'b0;
            r_last  <= r_owner;
            r_cnt   <= CNT_ZERO;
          end else if (!w_hold_done) begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        ST_RELEASE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= 4'b0000;
          r_valid <= 1'b0;
          r_cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign bus.Grant = r_grant;
  assign bus.Valid = r_valid;
  assign bus.Sel0  = r_sel0;
  assign bus.Sel1  = r_sel1;
  assign bus.Owner = r_owner;

endmodule

// File: doc/w_mux4_rr_arbiter.md
Name: w_mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-to-1 selector (D0..D3 -> Result) among four requesters.
- Requester k owns data input Dk.
- The arbiter grants one requester at a time and drives the selector's Sel0/Sel1 to route that requester's input to Result.
- A hold counter bounds how long one requester may keep the shared path while others wait.

Parameters:
- HOLD_MAX, 8, maximum consecutive GRANT cycles for one owner while another request is pending; legal range 1..(2^CNT_W)-1.
- CNT_W, 4, width of the hold counter.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST_N  input  1  reset, synchronous, active-low.
- Req  input  4  request lines; bit k = requester k wants input Dk.
- Grant  output  4  one-hot grant; all zero when no owner.
- Sel0  output  1  selector control, high-order select.
- Sel1  output  1  selector control, low-order select.
- Valid  output  1  high while Result carries the granted requester's data.
- Owner  output  2  index of the current or last owner.

Behaviour:
- Interface: one clock (CLK); reset RST_N is synchronous and active-low.
- Select encoding (fixed):
  - D0: Sel0=0, Sel1=0.
  - D1: Sel0=0, Sel1=1.
  - D2: Sel0=1, Sel1=0.
  - D3: Sel0=1, Sel1=1.
  - That is, Sel0=Owner[1] and Sel1=Owner[0].
- Reset (RST_N=0 at a rising edge), from any state including mid-grant:
  - state=IDLE, Grant=0000, Valid=0, Sel0=0, Sel1=0, Owner=0.
  - Priority pointer Last=3, so requester 0 is first in line; hold count=0.
- States:
  - IDLE: Grant=0, Valid=0, Sel held.
    - If Req!=0, pick the first set bit scanning (Last+1) mod 4, (Last+2) mod 4, ... with wrap-around.
    - Next cycle: state=GRANT, Owner=winner, Grant=one-hot(winner), Sel0/Sel1 from winner, Valid=1, count=1.
    - Latency is exactly one cycle from the sampled Req to the asserted Grant.
    - If Req=0, stay in IDLE.
  - GRANT:
    - If Req[Owner]=0 -> RELEASE.
    - Else if count>=HOLD_MAX and (Req & ~Grant)!=0 -> RELEASE (pre-emption).
    - Else stay in GRANT; count increments and saturates at HOLD_MAX.
    - With no competing request, the owner keeps the grant indefinitely.
  - RELEASE (exactly one cycle): Grant=0000, Valid=0, Last=Owner, count=0, Sel0/Sel1 unchanged; next state is always IDLE.
- Sel0/Sel1 change only on the IDLE->GRANT transition and on reset, so Result never switches while Valid=1.
- A new grant follows the end of the previous grant with a 2-cycle gap (RELEASE, then IDLE arbitration).
- Non-owner Req changes during GRANT have no effect except on the pre-emption test.
- Simultaneous events:
  - Owner drops Req in the same cycle the count reaches HOLD_MAX: treated as a normal release (same RELEASE path).
  - Multiple requests in IDLE: resolved by the rotating priority only.
- Req bits are registered-domain inputs (synchronous to CLK); no internal synchronisers.
- Outputs are registered; no combinational path from Req to any output.

Test Plan:
- Reset: hold RST_N=0 for 2 cycles with Req=1111 -> Grant=0000, Valid=0, Sel0=0, Sel1=0, Owner=0. Release reset -> one cycle later Grant=0001, Sel0=0, Sel1=0.
- Single request: Req=0100 held 5 cycles, then 0000 -> Grant=0100, Sel0=1, Sel1=0, Valid=1 for 5 cycles; then RELEASE (Grant=0000) for 1 cycle; then IDLE.
- Rotation: Req=1111 held constantly, HOLD_MAX=8 -> grants in order 0001, 0010, 0100, 1000, 0001. Each grant lasts 8 cycles, separated by 2-cycle gaps.
- Pre-emption boundary: requester 1 alone for 20 cycles, then Req=0011 at cycle 20 -> owner 1 keeps the grant (count saturated), is pre-empted on the next evaluation, and the next grant goes to requester 0 (wrap-around past 3).
- Reset mid-operation: assert RST_N=0 while Grant=1000, Sel0=1, Sel1=1 -> at the next edge all outputs return to reset values and Last=3; with Req=1000 after reset, the next grant goes to 1000.
- Select stability: toggle non-owner Req bits every cycle during a grant -> Sel0/Sel1/Grant remain constant until the RELEASE cycle.
